sysmem_byte_bridge: RTL and testbench

SYSMEM_BYTE_BRIDGE -- requirements
Module: sysmem_byte_bridge

---
 rtl/sysmem_byte_bridge_if.sv | 27 ++
 rtl/sysmem_byte_bridge.sv | 130 +++++++++++++
 tb/tb_sysmem_byte_bridge.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sysmem_byte_bridge_if.sv
// Bus bundle between a 32-bit CPU memory port and a byte-wide BRAM.
// The bridge uses the slave modport; the CPU/BRAM environment uses master.
interface sysmem_byte_bridge_if #(
    parameter int ADDR_W = 10
);
    logic              mem_valid;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_ce;
    logic              ram_we;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb, ram_dout,
        output mem_ready, mem_rdata, ram_addr, ram_ce, ram_we, ram_din
    );

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb, ram_dout,
        input  mem_ready, mem_rdata, ram_addr, ram_ce, ram_we, ram_din
    );
endinterface

// File: rtl/sysmem_byte_bridge.sv
// Serialises 32-bit CPU accesses into four byte accesses on an 8-bit BRAM.
// Optional macro SYSMEM_BRIDGE_SKIP_EN: writes visit only strobed lanes.
module sysmem_byte_bridge #(
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 resetn,
    sysmem_byte_bridge_if.slave  bus
);
    localparam int WORD_W = ADDR_W - 2;

    typedef enum logic [1:0] {IDLE, XFER, TAIL, DONE} state_e;

    state_e            state_q, state_d;
    logic [1:0]        lane_q, lane_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_ce_q, ram_ce_d;
    logic              ram_we_q, ram_we_d;
    logic [7:0]        ram_din_q, ram_din_d;
    logic              cap_en_q;
    logic [1:0]        cap_lane_q;
    logic              is_wr;
    logic              unused_addr_bits;

    assign is_wr            = |wstrb_q;
    assign unused_addr_bits = ^{bus.mem_addr[31:ADDR_W], bus.mem_addr[1:0]};

`ifdef SYSMEM_BRIDGE_SKIP_EN
    // Returns {found, lane} for the lowest strobed lane at or above 'from'.
    function automatic logic [2:0] find_lane(input logic [3:0] strb, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (strb[i] && (3'(i) >= from)) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    logic [2:0] skip_first, skip_next;
    assign skip_first = find_lane(bus.mem_wstrb, 3'd0);
    assign skip_next  = find_lane(wstrb_q, {1'b0, lane_q} + 3'd1);
`endif

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            IDLE: if (bus.mem_valid) begin
                word_d  = bus.mem_addr[ADDR_W-1:2];
                wdata_d = bus.mem_wdata;
                wstrb_d = bus.mem_wstrb;
                lane_d  = 2'd0;
`ifdef SYSMEM_BRIDGE_SKIP_EN
                if (bus.mem_wstrb != 4'b0000) lane_d = skip_first[1:0];
`endif
                state_d = XFER;
            end
            XFER: begin
`ifdef SYSMEM_BRIDGE_SKIP_EN
                if (is_wr) begin
                    if (skip_next[2]) lane_d = skip_next[1:0];
                    else              state_d = DONE;
                end else begin
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) state_d = TAIL;
                end
`else
                lane_d = lane_q + 2'd1;
                if (lane_q == 2'd3) state_d = is_wr ? DONE : TAIL;
`endif
            end
            TAIL:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // BRAM controls are registered, so they are computed from next state/lane.
        ram_ce_d   = (state_d == XFER);
        ram_we_d   = ram_ce_d && wstrb_d[lane_d];
        ram_addr_d = ram_ce_d ? {word_d, lane_d} : ram_addr_q;
        ram_din_d  = ram_ce_d ? wdata_d[8*lane_d +: 8] : ram_din_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            lane_q     <= 2'd0;
            word_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            ram_addr_q <= '0;
            ram_ce_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_din_q  <= '0;
            cap_en_q   <= 1'b0;
            cap_lane_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            ram_addr_q <= ram_addr_d;
            ram_ce_q   <= ram_ce_d;
            ram_we_q   <= ram_we_d;
            ram_din_q  <= ram_din_d;
            // BRAM data arrives one cycle after its lane was issued.
            cap_en_q   <= ram_ce_q && !is_wr;
            cap_lane_q <= ram_addr_q[1:0];
            if (cap_en_q) rdata_q[8*cap_lane_q +: 8] <= bus.ram_dout;
        end
    end

    assign bus.mem_ready = (state_q == DONE);
    assign bus.mem_rdata = rdata_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_ce    = ram_ce_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_din   = ram_din_q;
endmodule

// File: tb/tb_sysmem_byte_bridge.sv
// Directed testbench for sysmem_byte_bridge with a behavioural 1-cycle BRAM.
// Expectations follow SYSMEM_BRIDGE_SKIP_EN when it is defined.
module tb_sysmem_byte_bridge;
    localparam int ADDR_W = 10;
    localparam int NT     = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic preload = 1'b0;
    always #5 clk = ~clk;

    sysmem_byte_bridge_if #(.ADDR_W(ADDR_W)) bif ();

    sysmem_byte_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif.slave)
    );

    logic [7:0] mem [0:(1<<ADDR_W)-1];
    logic [7:0] ram_dout_q;
    assign bif.ram_dout = ram_dout_q;

    // Behavioural BRAM; the array has no reset, it is loaded by the preload strobe.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= 8'h00;
            mem[16] <= 8'h11; mem[17] <= 8'h22; mem[18] <= 8'h33; mem[19] <= 8'h44;
            mem[51] <= 8'h5A;
        end else if (bif.ram_ce) begin
            if (bif.ram_we) mem[bif.ram_addr] <= bif.ram_din;
            ram_dout_q <= mem[bif.ram_addr];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    logic              tr_ce    [1:NT];
    logic              tr_we    [1:NT];
    logic [ADDR_W-1:0] tr_addr  [1:NT];
    logic [7:0]        tr_din   [1:NT];
    logic [31:0]       tr_rdata [1:NT];
    logic [NT:1]       ce_v, we_v, rdy_v;

    // Presents one request in cycle T and records cycles T+1..T+NT.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int chg_k, input int drop_k, input int rst_k,
                           input bit b2b, input logic [31:0] b2b_a);
        bit again;
        again = b2b;
        @(negedge clk);
        bif.mem_valid = 1'b1; bif.mem_addr = a; bif.mem_wdata = d; bif.mem_wstrb = s;
        for (int k = 1; k <= NT; k++) begin
            @(posedge clk); @(negedge clk);
            tr_ce[k] = bif.ram_ce;  tr_we[k] = bif.ram_we;
            tr_addr[k] = bif.ram_addr; tr_din[k] = bif.ram_din;
            tr_rdata[k] = bif.mem_rdata;
            ce_v[k] = bif.ram_ce; we_v[k] = bif.ram_we; rdy_v[k] = bif.mem_ready;
            if (bif.mem_ready) begin
                if (again) begin
                    again = 1'b0; bif.mem_addr = b2b_a; bif.mem_wstrb = 4'b0000;
                end else bif.mem_valid = 1'b0;
            end
            if (k == chg_k) begin
                bif.mem_addr = 32'h50; bif.mem_wdata = 32'hFFFF_FFFF; bif.mem_wstrb = 4'b0000;
            end
            if (k == drop_k) bif.mem_valid = 1'b0;
            if (rst_k > 0 && k == rst_k) begin resetn = 1'b0; bif.mem_valid = 1'b0; end
            if (rst_k > 0 && k == rst_k + 1) resetn = 1'b1;
        end
        bif.mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        bif.mem_valid = 1'b0; bif.mem_addr = '0; bif.mem_wdata = '0; bif.mem_wstrb = '0;
        resetn = 1'b0; preload = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bif.mem_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got %b want 0", bif.mem_ready); end
        n_cmp++; if (bif.mem_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", bif.mem_rdata); end
        n_cmp++; if (bif.ram_ce !== 1'b0) begin n_err++; $display("FAIL rst_ce got %b want 0", bif.ram_ce); end
        n_cmp++; if (bif.ram_we !== 1'b0) begin n_err++; $display("FAIL rst_we got %b want 0", bif.ram_we); end
        n_cmp++; if (bif.ram_addr !== 10'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", bif.ram_addr); end
        n_cmp++; if (bif.ram_din !== 8'h0) begin n_err++; $display("FAIL rst_din got %h want 0", bif.ram_din); end
        preload = 1'b0; resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read(input logic [31:0] a, input logic [31:0] exp_data);
        run_txn(a, 32'h0, 4'b0000, 0, 0, 0, 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (tr_addr[k] !== 10'(a + 32'(k - 1)))
                begin n_err++; $display("FAIL rd_addr k=%0d got %h want %h", k, tr_addr[k], 10'(a + 32'(k - 1))); end
        end
        n_cmp++; if (tr_addr[5] !== 10'(a + 32'd3)) begin n_err++; $display("FAIL rd_addr_hold got %h want %h", tr_addr[5], 10'(a + 32'd3)); end
        n_cmp++; if (ce_v !== 16'h000F) begin n_err++; $display("FAIL rd_ce got %h want 000f", ce_v); end
        n_cmp++; if (we_v !== 16'h0000) begin n_err++; $display("FAIL rd_we got %h want 0000", we_v); end
        n_cmp++; if (rdy_v !== 16'h0020) begin n_err++; $display("FAIL rd_ready got %h want 0020", rdy_v); end
        n_cmp++; if (tr_rdata[6] !== exp_data) begin n_err++; $display("FAIL rd_data got %h want %h", tr_rdata[6], exp_data); end
    endtask

    task automatic test_write_full();
        logic [7:0] exp_din [0:3];
        exp_din[0] = 8'hEF; exp_din[1] = 8'hBE; exp_din[2] = 8'hAD; exp_din[3] = 8'hDE;
        run_txn(32'h20, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0, 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (tr_addr[k] !== 10'(32'h20 + 32'(k - 1)) || tr_din[k] !== exp_din[k-1])
                begin n_err++; $display("FAIL wr_lane k=%0d got %h/%h want %h/%h", k, tr_addr[k], tr_din[k], 10'(32'h20 + 32'(k - 1)), exp_din[k-1]); end
        end
        n_cmp++; if (we_v !== 16'h000F) begin n_err++; $display("FAIL wr_we got %h want 000f", we_v); end
        n_cmp++; if (rdy_v !== 16'h0010) begin n_err++; $display("FAIL wr_ready got %h want 0010", rdy_v); end
        n_cmp++; if (tr_rdata[5] !== 32'h4433_2211) begin n_err++; $display("FAIL wr_rdata_hold got %h want 44332211", tr_rdata[5]); end
    endtask

    task automatic test_write_partial();
        run_txn(32'h10, 32'h0000_AA00, 4'b0010, 0, 0, 0, 1'b0, 32'h0);
`ifdef SYSMEM_BRIDGE_SKIP_EN
        n_cmp++; if (ce_v !== 16'h0001) begin n_err++; $display("FAIL pw_ce got %h want 0001", ce_v); end
        n_cmp++; if (we_v !== 16'h0001) begin n_err++; $display("FAIL pw_we got %h want 0001", we_v); end
        n_cmp++; if (tr_addr[1] !== 10'h11) begin n_err++; $display("FAIL pw_addr got %h want 011", tr_addr[1]); end
        n_cmp++; if (rdy_v !== 16'h0002) begin n_err++; $display("FAIL pw_ready got %h want 0002", rdy_v); end
`else
        n_cmp++; if (ce_v !== 16'h000F) begin n_err++; $display("FAIL pw_ce got %h want 000f", ce_v); end
        n_cmp++; if (we_v !== 16'h0002) begin n_err++; $display("FAIL pw_we got %h want 0002", we_v); end
        n_cmp++; if (tr_din[2] !== 8'hAA) begin n_err++; $display("FAIL pw_din got %h want aa", tr_din[2]); end
        n_cmp++; if (rdy_v !== 16'h0010) begin n_err++; $display("FAIL pw_ready got %h want 0010", rdy_v); end
`endif
    endtask

    task automatic test_back_to_back();
        run_txn(32'h20, 32'h0, 4'b0000, 0, 0, 0, 1'b1, 32'h10);
        n_cmp++; if (rdy_v !== 16'h1020) begin n_err++; $display("FAIL b2b_ready got %h want 1020", rdy_v); end
        n_cmp++; if (tr_rdata[6] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL b2b_data0 got %h want deadbeef", tr_rdata[6]); end
        n_cmp++; if (tr_ce[7] !== 1'b0) begin n_err++; $display("FAIL b2b_idle_gap got %b want 0", tr_ce[7]); end
        n_cmp++; if (tr_ce[8] !== 1'b1 || tr_addr[8] !== 10'h10) begin n_err++; $display("FAIL b2b_start got %b/%h want 1/010", tr_ce[8], tr_addr[8]); end
        n_cmp++; if (tr_rdata[13] !== 32'h4433_AA11) begin n_err++; $display("FAIL b2b_data1 got %h want 4433aa11", tr_rdata[13]); end
    endtask

    task automatic test_input_change();
        run_txn(32'h40, 32'h8765_4321, 4'b1111, 2, 3, 0, 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            n_cmp++;
            if (tr_addr[k] !== 10'(32'h40 + 32'(k - 1)))
                begin n_err++; $display("FAIL chg_addr k=%0d got %h want %h", k, tr_addr[k], 10'(32'h40 + 32'(k - 1))); end
        end
        n_cmp++; if ({mem[67], mem[66], mem[65], mem[64]} !== 32'h8765_4321)
            begin n_err++; $display("FAIL chg_bytes got %h want 87654321", {mem[67], mem[66], mem[65], mem[64]}); end
        n_cmp++; if (mem[80] !== 8'h00) begin n_err++; $display("FAIL chg_stray got %h want 00", mem[80]); end
        n_cmp++; if (rdy_v !== 16'h0010) begin n_err++; $display("FAIL chg_ready got %h want 0010", rdy_v); end
    endtask

    task automatic test_reset_mid();
        run_txn(32'h30, 32'h0102_0304, 4'b1111, 0, 0, 3, 1'b0, 32'h0);
        n_cmp++; if (we_v !== 16'h0007) begin n_err++; $display("FAIL rm_we got %h want 0007", we_v); end
        n_cmp++; if (ce_v !== 16'h0007) begin n_err++; $display("FAIL rm_ce got %h want 0007", ce_v); end
        n_cmp++; if (rdy_v !== 16'h0000) begin n_err++; $display("FAIL rm_ready got %h want 0000", rdy_v); end
        n_cmp++; if (tr_addr[4] !== 10'h0 || tr_din[4] !== 8'h0 || tr_rdata[4] !== 32'h0)
            begin n_err++; $display("FAIL rm_zero got %h/%h/%h want 0/0/0", tr_addr[4], tr_din[4], tr_rdata[4]); end
        n_cmp++; if (mem[51] !== 8'h5A) begin n_err++; $display("FAIL rm_lane3 got %h want 5a", mem[51]); end
    endtask

    initial begin
        test_reset();
        test_read(32'h10, 32'h4433_2211);
        test_write_full();
        test_read(32'h20, 32'hDEAD_BEEF);
        test_write_partial();
        test_read(32'h10, 32'h4433_AA11);
        test_back_to_back();
        test_input_change();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
